// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - unified instruction/data word memory responder for the multicycle MIPS datapath
// Captures one request in IDLE, waits LATENCY cycles, commits on entry to RESP and pulses MemReady.
module mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Addr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  MemReady,
  output logic                  Busy,
  output logic                  AddrErr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam bit         LAT_ZERO = (LATENCY == 0);
  localparam logic [3:0] LAT_LOAD = LAT_ZERO ? 4'd0 : 4'(LATENCY - 1);

  state_t                  state_q;
  logic [3:0]              count_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    aerr_q;
  logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];

  logic                    req;
  logic                    req_err;
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic                    in_idle;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   c_idx;
  logic [DATA_WIDTH-1:0]   c_wdata;
  logic                    c_write;
  logic                    c_err;

  assign req     = MemRead | MemWrite;
  assign req_err = (Addr[1:0] != 2'b00) || (Addr[31:ADDR_WIDTH+2] != '0) || (MemRead && MemWrite);
  assign req_idx = Addr[ADDR_WIDTH+1:2];
  assign in_idle = (state_q == S_IDLE);

  // With zero latency the capture edge is also the commit edge, so live inputs feed the commit.
  assign commit  = (in_idle && req && LAT_ZERO) || (state_q == S_WAIT && count_q == 4'd0);
  assign c_idx   = in_idle ? req_idx   : idx_q;
  assign c_wdata = in_idle ? WriteData : wdata_q;
  assign c_write = in_idle ? MemWrite  : write_q;
  assign c_err   = in_idle ? req_err   : err_q;

  // Array is never reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge Clk) begin
    if (Reset && commit && c_write && !c_err) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      aerr_q  <= 1'b0;
      if (commit) begin
        ready_q <= 1'b1;
        aerr_q  <= c_err;
        if (!c_write && !c_err) begin
          rdata_q <= mem_q[c_idx];
        end
      end
      case (state_q)
        S_IDLE: begin
          if (req) begin
            idx_q   <= req_idx;
            wdata_q <= WriteData;
            write_q <= MemWrite;
            err_q   <= req_err;
            busy_q  <= 1'b1;
            if (LAT_ZERO) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              count_q <= LAT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (count_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign Busy     = busy_q;
  assign AddrErr  = aerr_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (LATENCY=2 and LATENCY=0 builds)
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mr, mw, en0;
  logic        mr0, mw0;
  logic [31:0] addr, wd;
  logic [31:0] rd2, rd0;
  logic        rdy2, busy2, err2;
  logic        rdy0, busy0, err0;

  logic [31:0] ref_mem [256];
  logic [31:0] exp_rd2, exp_rd0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign mr0 = mr & en0;
  assign mw0 = mw & en0;

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(LAT)) u_dut2 (
    .Clk(clk), .Reset(resetn), .MemRead(mr), .MemWrite(mw), .Addr(addr), .WriteData(wd),
    .ReadData(rd2), .MemReady(rdy2), .Busy(busy2), .AddrErr(err2)
  );

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(0)) u_dut0 (
    .Clk(clk), .Reset(resetn), .MemRead(mr0), .MemWrite(mw0), .Addr(addr), .WriteData(wd),
    .ReadData(rd0), .MemReady(rdy0), .Busy(busy0), .AddrErr(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One complete access; expected results come from the word-array model.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic valid;
    int   n;
    valid = (a[1:0] == 2'b00) && (a < 32'h400) && !(rd && wr);
    if (valid && wr) ref_mem[a[9:2]] = d;
    if (valid && !wr) begin
      exp_rd2 = ref_mem[a[9:2]];
      if (en0) exp_rd0 = ref_mem[a[9:2]];
    end
    @(negedge clk);
    mr = rd; mw = wr; addr = a; wd = d;
    @(negedge clk);
    mr = 1'b0; mw = 1'b0; addr = $urandom; wd = $urandom;
    if (en0) begin
      chk("lat0_ready", 32'(rdy0), 32'd1);
      chk("lat0_err", 32'(err0), 32'(!valid));
      chk("lat0_rdata", rd0, exp_rd0);
    end
    chk("busy_wait", 32'(busy2), 32'd1);
    n = 1;
    while (rdy2 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(LAT + 1));
    chk("addr_err", 32'(err2), 32'(!valid));
    chk("rdata", rd2, exp_rd2);
    @(negedge clk);
    chk("ready_drop", 32'(rdy2), 32'd0);
    chk("err_drop", 32'(err2), 32'd0);
    chk("busy_idle", 32'(busy2), 32'd0);
    chk("rdata_hold", rd2, exp_rd2);
    if (en0) chk("lat0_ready_drop", 32'(rdy0), 32'd0);
  endtask

  initial begin
    int          pulses;
    logic [31:0] a;
    logic        r, w;
    resetn = 1'b0; mr = 1'b0; mw = 1'b0; en0 = 1'b1; addr = '0; wd = '0;
    exp_rd2 = '0; exp_rd0 = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rd2, 32'd0);
    chk("rst_ready", 32'(rdy2), 32'd0);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 256; i++) access(1'b0, 1'b1, 32'(i * 4), 32'd0);

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0);
    chk("readback", rd2, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h14, 32'h0);
    access(1'b0, 1'b1, 32'h13, 32'h12345678);
    access(1'b1, 1'b0, 32'h10, 32'h0);
    access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
    access(1'b1, 1'b1, 32'h10, 32'h11111111);
    access(1'b1, 1'b0, 32'h10, 32'h0);
    access(1'b1, 1'b0, 32'h0, 32'h0);
    chk("oor_no_alias", rd2, 32'd0);

    // Held read strobe: captures at E0 and E4, Addr wiggle during WAIT must not matter.
    en0 = 1'b0;
    pulses = 0;
    @(negedge clk);
    mr = 1'b1; addr = 32'h10;
    for (int s = 1; s <= 12; s++) begin
      @(negedge clk);
      if (s == 1) addr = 32'h14;
      if (s == 3) addr = 32'h10;
      if (s == 8) mr = 1'b0;
      if (rdy2) pulses++;
      if (s == 3 || s == 7) begin
        chk("held_ready", 32'(rdy2), 32'd1);
        chk("held_rdata", rd2, ref_mem[4]);
      end
      if (s == 4) chk("held_busy_gap", 32'(busy2), 32'd0);
      if (s == 5) chk("held_busy_again", 32'(busy2), 32'd1);
    end
    chk("held_pulses", 32'(pulses), 32'd2);
    exp_rd2 = ref_mem[4];
    en0 = 1'b1;

    // Reset during WAIT of a write aborts it.
    access(1'b0, 1'b1, 32'h20, 32'h5A5A1234);
    en0 = 1'b0;
    @(negedge clk);
    mw = 1'b1; addr = 32'h20; wd = 32'hCAFEF00D;
    @(negedge clk);
    mw = 1'b0; resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midrst_busy", 32'(busy2), 32'd0);
    chk("midrst_rdata", rd2, 32'd0);
    exp_rd2 = '0; exp_rd0 = '0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy2) pulses++;
    end
    chk("midrst_no_ready", 32'(pulses), 32'd0);
    en0 = 1'b1;
    access(1'b1, 1'b0, 32'h20, 32'h0);
    chk("midrst_old", rd2, 32'h5A5A1234);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0: a = {22'd0, 8'($urandom_range(0, 255)), 2'(($urandom_range(1, 3)))};
        1: a = (32'($urandom_range(1, 1000)) << 10) | {22'd0, 8'($urandom_range(0, 15)), 2'b00};
        default: a = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
      endcase
      r = 1'($urandom_range(0, 1));
      w = !r;
      if ($urandom_range(0, 9) == 0) begin r = 1'b1; w = 1'b1; end
      access(r, w, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle MIPS datapath: a unified instruction/data word memory.
- Services MemRead/MemWrite strobes from the controller, using the address selected by the lorD mux.
- Access latency is configurable. Completion is signalled by a one-cycle MemReady pulse, and read data is held in a registered output.
- Misaligned and out-of-range accesses are trapped and flagged instead of corrupting the array.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 8, log2 of word count; array holds 2^ADDR_WIDTH words.
- LATENCY, 2, wait cycles between request capture and response; legal range 0..15.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset (0 = reset).
- MemRead  input  1  read request strobe.
- MemWrite  input  1  write request strobe.
- Addr  input  32  byte address; must be word-aligned.
- WriteData  input  DATA_WIDTH  store data.
- ReadData  output  DATA_WIDTH  registered read data.
- MemReady  output  1  one-cycle completion pulse.
- Busy  output  1  high while in WAIT or RESP.
- AddrErr  output  1  one-cycle error pulse, coincident with MemReady.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - state=IDLE, wait counter=0.
  - ReadData=0, MemReady=0, Busy=0, AddrErr=0.
  - Array contents are NOT cleared.
  - Reset mid-access aborts the access. A write is not committed unless its commit edge has already passed.
- FSM states:
  - IDLE: accept a request.
  - WAIT: count down.
  - RESP: respond for one cycle.
- IDLE:
  - If MemRead|MemWrite is high at edge E0, capture Addr, WriteData and the op.
  - Next state is WAIT with count=LATENCY-1, or RESP directly if LATENCY==0.
- WAIT:
  - Decrement the counter each edge.
  - At the edge where count==0, go to RESP (this is the commit edge).
- Commit edge (entry to RESP), for a valid op:
  - Read: ReadData <= array[captured word index].
  - Write: array[index] <= captured WriteData; ReadData unchanged.
- RESP:
  - MemReady=1 for exactly one cycle, then IDLE unconditionally.
  - Strobes are ignored while in RESP.
- Latency:
  - MemReady is high in the cycle after edge E0+LATENCY.
  - Back-to-back throughput is one access per LATENCY+2 cycles.
  - A strobe held high from RESP is re-captured at the first edge in IDLE, i.e. a repeated access.
- Strobes in WAIT or RESP are ignored; captured values are not disturbed by Addr or WriteData changes after E0.
- Word index = captured Addr[ADDR_WIDTH+1:2].
- Error cases: any of the following makes the op invalid.
  - Addr[1:0]!=0 (misaligned).
  - Addr[31:ADDR_WIDTH+2]!=0 (out of range).
  - MemRead and MemWrite both high at capture.
- Invalid op handling:
  - Normal latency is still taken.
  - AddrErr=1 together with MemReady in RESP.
  - No array write occurs; ReadData holds its old value.
- Outputs are all registered. Busy = (state!=IDLE).
- MemReady and AddrErr are 0 outside RESP.

Test Plan:
- Reset and write: release Reset, then MemWrite=1, Addr=0x10, WriteData=0xDEADBEEF with LATENCY=2 → MemReady pulses exactly 3 cycles after capture, AddrErr=0, ReadData stays 0.
- Read-back: MemRead=1, Addr=0x10 → MemReady 3 cycles after capture with ReadData=0xDEADBEEF, held after MemReady drops. Then read Addr=0x14 (never written, preloaded 0x00000000) → ReadData=0.
- Misaligned address: MemWrite=1, Addr=0x13, WriteData=0x12345678 → MemReady=1 and AddrErr=1 together. Subsequent read of 0x10 still returns 0xDEADBEEF.
- Out of range and conflicting strobes:
  - Addr=0x400 with ADDR_WIDTH=8 → AddrErr pulse, no write.
  - MemRead=MemWrite=1 at Addr=0x10 → AddrErr pulse, array unchanged.
- Held strobe and ignored change: hold MemRead=1 at Addr=0x10 for 10 cycles → MemReady pulses at cycles 3 and 7 after first capture (period 4), Busy low for one cycle between accesses. Changing Addr during WAIT has no effect.
- Reset mid-access and LATENCY=0:
  - Assert Reset during WAIT of a write of 0xCAFEF00D to 0x20 → no MemReady; later read of 0x20 returns the old value.
  - Rebuild with LATENCY=0 → MemReady is high the cycle after capture.
